// File: rtl/mux_4to1_arbiter_pkg.sv
// Shared types and the round-robin pick function for the four-requester mux arbiter.
package mux_arb_pkg;

    typedef enum logic {IDLE, XFER} arb_state_t;

    localparam int NUM_REQ = 4;

    // Scan ptr+1, ptr+2, ptr+3, ptr (mod 4); first set bit wins, so iterate backwards.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = 2'd0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    function automatic logic [3:0] idx2oh(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_4to1_arbiter_if.sv
// Requester/consumer bundle of the mux arbiter; lock exists only with MUX_ARB_LOCK_EN.
interface mux_4to1_arbiter_if #(parameter int n = 8);
    logic [3:0]   req;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic [n-1:0] c;
    logic [n-1:0] d;
    logic [3:0]   ack;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic         en;
    logic [n-1:0] y;
    logic         y_valid;
    logic         y_ready;
`ifdef MUX_ARB_LOCK_EN
    logic [3:0]   lock;
`endif

    modport master (
`ifdef MUX_ARB_LOCK_EN
        output lock,
`endif
        output req, a, b, c, d, y_ready,
        input  ack, grant, sel, en, y, y_valid
    );

    modport slave (
`ifdef MUX_ARB_LOCK_EN
        input  lock,
`endif
        input  req, a, b, c, d, y_ready,
        output ack, grant, sel, en, y, y_valid
    );
endinterface

// File: rtl/mux_4to1.sv
// Plain 4:1 n-bit mux datapath; output forced to zero while disabled.
module mux_4to1 #(parameter int n = 8) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [n-1:0] c,
    input  logic [n-1:0] d,
    input  logic         en,
    input  logic [1:0]   sel,
    output logic [n-1:0] y
);
    always_comb begin
        y = '0;
        if (en) begin
            case (sel)
                2'd0:    y = a;
                2'd1:    y = b;
                2'd2:    y = c;
                default: y = d;
            endcase
        end
    end
endmodule

// File: rtl/mux_4to1_arbiter.sv
// Round-robin arbiter sharing one mux_4to1 among four requesters.
// Optional burst lock input is compiled in with MUX_ARB_LOCK_EN.
//
// state | meaning
// IDLE  | no grant held, waiting for any req
// XFER  | grant held, word offered on y with valid/ready
module mux_4to1_arbiter
    import mux_arb_pkg::*;
#(parameter int n = 8) (
    input logic          clk,
    input logic          rst,
    mux_4to1_arbiter_if.slave bus
);
    arb_state_t   state, state_next;
    logic [3:0]   grant, grant_next;
    logic [1:0]   sel, sel_next;
    logic         en, en_next;
    logic [1:0]   ptr, ptr_next;
    logic [3:0]   ack;
    logic         y_valid;
    logic [1:0]   pick;
    logic [3:0]   masked;
    logic         lock_hold;
    logic [n-1:0] y_mux;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= 4'b0000;
            sel   <= 2'd0;
            en    <= 1'b0;
            ptr   <= 2'd3;
        end else begin
            state <= state_next;
            grant <= grant_next;
            sel   <= sel_next;
            en    <= en_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        sel_next   = sel;
        en_next    = en;
        ptr_next   = ptr;
        ack        = 4'b0000;
        y_valid    = 1'b0;
        pick       = 2'd0;
        masked     = 4'b0000;
        lock_hold  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    pick       = rr_pick(bus.req, ptr);
                    state_next = XFER;
                    grant_next = idx2oh(pick);
                    sel_next   = pick;
                    en_next    = 1'b1;
                end
            end
            XFER: begin
                if (!bus.req[sel]) begin
                    state_next = IDLE;
                    grant_next = 4'b0000;
                    sel_next   = 2'd0;
                    en_next    = 1'b0;
                end else begin
                    // reset in the same cycle suppresses the handshake entirely
                    y_valid = !rst;
                    if (bus.y_ready && !rst) begin
                        ack = idx2oh(sel);
`ifdef MUX_ARB_LOCK_EN
                        lock_hold = bus.lock[sel];
`endif
                        if (!lock_hold) begin
                            ptr_next = sel;
                            masked   = bus.req & ~idx2oh(sel);
                            if (masked != 4'b0000) begin
                                pick       = rr_pick(masked, sel);
                                grant_next = idx2oh(pick);
                                sel_next   = pick;
                            end else begin
                                state_next = IDLE;
                                grant_next = 4'b0000;
                                sel_next   = 2'd0;
                                en_next    = 1'b0;
                            end
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mux_4to1 #(.n(n)) u_mux (
        .a   (bus.a),
        .b   (bus.b),
        .c   (bus.c),
        .d   (bus.d),
        .en  (en),
        .sel (sel),
        .y   (y_mux)
    );

    assign bus.ack     = ack;
    assign bus.grant   = grant;
    assign bus.sel     = sel;
    assign bus.en      = en;
    assign bus.y       = y_mux;
    assign bus.y_valid = y_valid;
endmodule

// File: tb/tb_mux_4to1_arbiter.sv
// Directed bench for mux_4to1_arbiter; accepted words are checked against a scoreboard queue.
module tb_mux_4to1_arbiter;
    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mux_4to1_arbiter_if #(.n(8)) bus();

    mux_4to1_arbiter #(.n(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] ack, input logic [7:0] y);
        exp_t e;
        e.ack = ack;
        e.y   = y;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Every accepted word must match the next queued expectation; otherwise ack must be idle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.y_valid === 1'b1 && bus.y_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_unexpected: observed ack %0h y %0h expected no transfer", bus.ack, bus.y);
            end else begin
                e = sb.pop_front();
                chk("sb_ack", 32'(bus.ack), 32'(e.ack));
                chk("sb_y", 32'(bus.y), 32'(e.y));
            end
        end else begin
            chk("ack_idle", 32'(bus.ack), 32'd0);
        end
    end

    initial begin
        rst         = 1'b1;
        bus.req     = 4'b1111;
        bus.y_ready = 1'b1;
        bus.a       = 8'h11;
        bus.b       = 8'h22;
        bus.c       = 8'h33;
        bus.d       = 8'h44;
`ifdef MUX_ARB_LOCK_EN
        bus.lock    = 4'b0000;
`endif
        step(); samp();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_valid", 32'(bus.y_valid), 32'd0);
        chk("rst_en", 32'(bus.en), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        step(); rst = 1'b0; samp();
        chk("rel_grant", 32'(bus.grant), 32'd0);
        chk("rel_valid", 32'(bus.y_valid), 32'd0);

        // round-robin with all four requesting: 0,1,2,3,0
        push(4'b0001, 8'h11); push(4'b0010, 8'h22); push(4'b0100, 8'h33);
        push(4'b1000, 8'h44); push(4'b0001, 8'h11);
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 4) bus.req = 4'b0001;
            samp();
            chk("rr_grant", 32'(bus.grant), 32'(4'b0001 << (k % 4)));
            chk("rr_valid", 32'(bus.y_valid), 32'd1);
        end

        // single request on c
        step(); bus.req = 4'b0100; bus.c = 8'hAA; push(4'b0100, 8'hAA); samp();
        chk("idle_en", 32'(bus.en), 32'd0);
        chk("idle_grant", 32'(bus.grant), 32'd0);
        chk("idle_y", 32'(bus.y), 32'd0);
        step(); samp();
        chk("single_sel", 32'(bus.sel), 32'd2);
        chk("single_y", 32'(bus.y), 32'hAA);
        chk("single_valid", 32'(bus.y_valid), 32'd1);

        // stall on requester 1 while requester 3 arrives late
        step(); bus.req = 4'b0010; bus.y_ready = 1'b0; push(4'b0010, 8'h22); samp();
        chk("single_idle_en", 32'(bus.en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 0) bus.req = 4'b1010;
            samp();
            chk("stall_grant", 32'(bus.grant), 32'b0010);
            chk("stall_y", 32'(bus.y), 32'h22);
            chk("stall_valid", 32'(bus.y_valid), 32'd1);
        end
        step(); bus.y_ready = 1'b1; push(4'b1000, 8'h44); samp();
        chk("stall_end_grant", 32'(bus.grant), 32'b0010);
        chk("stall_end_y", 32'(bus.y), 32'h22);
        step(); bus.req = 4'b1000; samp();
        chk("late_grant", 32'(bus.grant), 32'b1000);
        chk("late_y", 32'(bus.y), 32'h44);

        // requester 3 re-requests, then aborts before ready
        step(); bus.y_ready = 1'b0; samp();
        chk("rereq_idle_en", 32'(bus.en), 32'd0);
        step(); bus.req = 4'b0000; samp();
        chk("abort_grant", 32'(bus.grant), 32'b1000);
        chk("abort_valid", 32'(bus.y_valid), 32'd0);
        chk("abort_y", 32'(bus.y), 32'h44);
        step(); bus.req = 4'b1001; bus.y_ready = 1'b1;
        push(4'b0001, 8'h11); push(4'b1000, 8'h44); samp();
        chk("abort_idle_grant", 32'(bus.grant), 32'd0);
        chk("abort_idle_en", 32'(bus.en), 32'd0);
        step(); samp();
        chk("abort_ptr_grant", 32'(bus.grant), 32'b0001);
        step(); bus.req = 4'b1000; samp();
        chk("b2b_grant", 32'(bus.grant), 32'b1000);
        step(); bus.req = 4'b0000; samp();
        chk("b2b_idle_en", 32'(bus.en), 32'd0);

        // reset arriving during a would-be handshake
        step(); bus.req = 4'b0010; samp();
        step(); rst = 1'b1; samp();
        chk("midrst_grant", 32'(bus.grant), 32'b0010);
        chk("midrst_valid", 32'(bus.y_valid), 32'd0);
        step(); rst = 1'b0; bus.req = 4'b0000; samp();
        chk("midrst_after_grant", 32'(bus.grant), 32'd0);
        chk("midrst_after_sel", 32'(bus.sel), 32'd0);

`ifdef MUX_ARB_LOCK_EN
        step(); bus.lock = 4'b0001; bus.req = 4'b0011;
        push(4'b0001, 8'h11); push(4'b0001, 8'h11); push(4'b0001, 8'h11); push(4'b0010, 8'h22);
        samp();
        step(); samp();
        chk("lock_grant1", 32'(bus.grant), 32'b0001);
        step(); samp();
        chk("lock_grant2", 32'(bus.grant), 32'b0001);
        step(); bus.lock = 4'b0000; samp();
        chk("lock_grant3", 32'(bus.grant), 32'b0001);
        step(); bus.req = 4'b0010; samp();
        chk("unlock_grant", 32'(bus.grant), 32'b0010);
        step(); bus.req = 4'b0000; samp();
        chk("unlock_idle_en", 32'(bus.en), 32'd0);
`endif

        repeat (2) begin step(); samp(); end
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux_4to1_arbiter.md
Name: mux_4to1_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4:1 n-bit mux datapath among four requesters.
- Each requester presents data with a request; the block grants one requester at a time.
- It drives the mux select and enable, and presents the selected word on a valid/ready output handshake.
- It sits between four producer blocks and a single downstream consumer in the catalog datapath.

Parameters:
n, 8, data width of each requester word and of output y

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  4  req[i]=1: requester i has a word on its data input (a=0, b=1, c=2, d=3)
a  input  n  requester 0 data
b  input  n  requester 1 data
c  input  n  requester 2 data
d  input  n  requester 3 data
ack  output  4  one-hot, one-cycle pulse: word of requester i accepted downstream
grant  output  4  one-hot, registered: current owner of the mux
sel  output  2  registered mux select, equals index of grant
en  output  1  registered mux enable, 1 while a grant is held
y  output  n  mux output: selected word when en=1, else 0
y_valid  output  1  y holds a valid word
y_ready  input  1  downstream accepts y when y_valid and y_ready are both 1

Behaviour:
- Single clock domain; all state updates on posedge clk.
- rst is synchronous and active-high. On reset:
  - state=IDLE, grant=0, sel=0, en=0, ack=0, y_valid=0.
  - Priority pointer ptr=3, so requester 0 has highest priority first.
- States: IDLE, XFER.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, at the next edge, grant the first i with req[i]=1, scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Set grant, sel and en=1, and go to XFER. Latency is one cycle from req to y_valid.
- XFER:
  - y_valid=1 combinationally while req[sel]=1. y is the mux output of the live data input, so requesters hold data stable until ack.
  - Handshake (y_valid && y_ready):
    - ack[sel]=1 for exactly that cycle; ptr<=sel.
    - Next state is chosen from req with requester sel masked out (its ack is in flight):
      - If other reqs are pending, take the next grant directly in XFER. Throughput is one word per cycle.
      - Otherwise go to IDLE with grant=0, en=0.
  - Granted req drops before handshake (abort): y_valid=0 that cycle, no ack, ptr unchanged, next state IDLE with grant=0.
  - y_ready=0 (stall): hold grant, sel and y; newly arriving reqs wait.
- Re-request: a requester keeping req=1 after its ack is a new request and gets lowest priority next round.
- Mid-operation reset: rst wins over any handshake in the same cycle; no ack is issued.
- ack is never asserted for a requester whose req is 0.

Optional Feature:
Macro MUX_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (4 bits).
  - If lock[sel]=1 at a handshake and req[sel] is still 1, the grant stays with sel and ptr is not updated. Burst transfer, other requesters wait.
  - Lock is ignored in IDLE.
- Undefined: no lock port; behaviour is exactly the round-robin scheme above.

Decomposition:
- Package mux_arb_pkg holds:
  - typedef enum logic {IDLE, XFER} arb_state_t
  - constant NUM_REQ=4
  - function rr_pick(req, ptr), returning the 2-bit index of the next requester.
- Sub-module: instantiate the existing mux_4to1 (parameter n; ports a, b, c, d, en, sel, y) as the datapath. The arbiter supplies sel and en only.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> grant=0, ack=0, y_valid=0, en=0. First grant after release is requester 0.
- Single request: req=4'b0100, c=8'hAA, y_ready=1 -> next cycle sel=2'b10, y=8'hAA, y_valid=1, ack=4'b0100. Return to IDLE.
- Round-robin: req=4'b1111 held, y_ready=1, a..d=8'h11/22/33/44 -> y sequence 11, 22, 33, 44, 11 on consecutive cycles; ack rotates 0001, 0010, 0100, 1000.
- Stall: grant on requester 1, y_ready=0 for 3 cycles, then 1 -> y stable at b for 4 cycles, single ack pulse, no grant change.
- Abort: granted requester 3 drops req before y_ready -> y_valid=0, no ack, IDLE next. A later req=4'b1001 grants requester 0 (ptr unchanged).
- With MUX_ARB_LOCK_EN: lock=4'b0001, req=4'b0011 -> requester 0 gets 3 consecutive acks. Lock drops -> requester 1 granted next.
